// File: rtl/wrr_pop_scheduler_pkg.sv
// Shared types and constants for the weighted round-robin pop scheduler.
package wrr_pop_scheduler_pkg;

  localparam int unsigned NQ = 4;
  localparam int unsigned WW = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StServe = 1'b1
  } state_e;

  // Effective burst length of queue q; a zero weight still allows one pop.
  function automatic logic [WW-1:0] weff(input logic [NQ*WW-1:0] w, input logic [1:0] q);
    logic [WW-1:0] f;
    f = w[WW*q +: WW];
    return (f == '0) ? WW'(1) : f;
  endfunction

endpackage

// File: rtl/wrr_pop_scheduler_rr_next_sel.sv
// Rotating priority search: first requester after ptr, wrapping, with ptr itself visited last.
module wrr_pop_scheduler_rr_next_sel
  import wrr_pop_scheduler_pkg::*;
(
  input  logic [NQ-1:0] req,
  input  logic [1:0]    ptr,
  output logic [1:0]    sel,
  output logic          found
);

  // Walk from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = int'(NQ); k >= 1; k--) begin
      if (req[ptr + 2'(k)]) begin
        sel   = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin scheduler choosing which of four input FIFOs to pop each cycle.
module wrr_pop_scheduler
  import wrr_pop_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NQ*WW-1:0] weights,
  input  logic [NQ-1:0]    empty,
  input  logic             dest_full,
  output logic [NQ-1:0]    pop,
  output logic             valid,
  output logic [1:0]       pop_id,
  output logic             busy,
  output logic [1:0]       grant_q
);

  state_e        state_q, state_d;
  logic [1:0]    grant_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [WW-1:0] count_q, count_d;
  logic [WW:0]   count_inc;
  logic [NQ-1:0] req;
  logic [1:0]    search_ptr;
  logic [1:0]    sel;
  logic          found;
  logic          burst_end;

  assign req        = ~empty;
  // IDLE searches after the last served queue; SERVE rearbitrates after the current one.
  assign search_ptr = (state_q == StServe) ? grant_q : ptr_q;
  assign count_inc  = {1'b0, count_q} + (WW+1)'(1);
  assign busy       = (state_q == StServe);

  wrr_pop_scheduler_rr_next_sel u_rr_next_sel (
    .req   (req),
    .ptr   (search_ptr),
    .sel   (sel),
    .found (found)
  );

  always_comb begin
    pop       = '0;
    state_d   = state_q;
    grant_d   = grant_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    burst_end = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            state_d = StServe;
            grant_d = sel;
            count_d = '0;
          end
        end
        StServe: begin
          if (empty[grant_q]) begin
            burst_end = 1'b1;
          end else if (!dest_full) begin
            pop[grant_q] = 1'b1;
            // >= so a weight lowered below the running count ends the burst now.
            if (count_inc >= {1'b0, weff(weights, grant_q)}) begin
              burst_end = 1'b1;
            end else begin
              count_d = count_inc[WW-1:0];
            end
          end
          if (burst_end) begin
            ptr_d   = grant_q;
            count_d = '0;
            if (found) begin
              grant_d = sel;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      count_q <= '0;
      ptr_q   <= 2'd3;
      valid   <= 1'b0;
      pop_id  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      valid   <= |pop;
      if (|pop) begin
        pop_id <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Directed bench for wrr_pop_scheduler with hand-computed pop sequences.
module tb_wrr_pop_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] weights = 16'h1111;
  logic [3:0]  empty = 4'b0000;
  logic        dest_full = 1'b0;
  logic [3:0]  pop;
  logic        valid;
  logic [1:0]  pop_id;
  logic        busy;
  logic [1:0]  grant_q;

  int   errors = 0;
  int   checks = 0;
  logic       exp_valid = 1'b0;
  logic [1:0] exp_id = 2'd0;

  wrr_pop_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .weights   (weights),
    .empty     (empty),
    .dest_full (dest_full),
    .pop       (pop),
    .valid     (valid),
    .pop_id    (pop_id),
    .busy      (busy),
    .grant_q   (grant_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at posedge+1 with inputs applied: checks pop this cycle, then valid/pop_id after the edge.
  task automatic expect_pop(input string tag, input logic [3:0] exp);
    #1;
    chk({tag, " pop"}, 16'(pop), 16'(exp));
    exp_valid = |exp;
    if (|exp) exp_id = exp[1] ? 2'd1 : exp[2] ? 2'd2 : exp[3] ? 2'd3 : 2'd0;
    @(posedge clk);
    #1;
    chk({tag, " valid"}, 16'(valid), 16'(exp_valid));
    chk({tag, " pop_id"}, 16'(pop_id), 16'(exp_id));
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, " rst pop"}, 16'(pop), 16'h0);
    chk({tag, " rst valid"}, 16'(valid), 16'h0);
    chk({tag, " rst pop_id"}, 16'(pop_id), 16'h0);
    chk({tag, " rst busy"}, 16'(busy), 16'h0);
    chk({tag, " rst grant"}, 16'(grant_q), 16'h0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    exp_valid = 1'b0;
    exp_id    = 2'd0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (((pop & empty) == 4'b0) && !(dest_full && |pop) && $onehot0(pop)) else begin
        errors++;
        $error("FAIL invariant: pop=%b empty=%b dest_full=%b", pop, empty, dest_full);
      end
    end
  end

  initial begin
    // Reset behaviour and plain rotation
    @(posedge clk);
    #1;
    chk("t1 in-reset pop", 16'(pop), 16'h0);
    chk("t1 in-reset valid", 16'(valid), 16'h0);
    chk("t1 in-reset pop_id", 16'(pop_id), 16'h0);
    reset = 1'b0;
    expect_pop("t1 idle", 4'b0000);
    expect_pop("t1 q0", 4'b0001);
    expect_pop("t1 q1", 4'b0010);
    expect_pop("t1 q2", 4'b0100);
    expect_pop("t1 q3", 4'b1000);
    expect_pop("t1 q0 wrap", 4'b0001);

    // Weighted bursts: q0=3, q1=0(->1), q2=2, q3=1
    weights = 16'h1203;
    do_reset("t2");
    expect_pop("t2 idle", 4'b0000);
    expect_pop("t2 q0a", 4'b0001);
    expect_pop("t2 q0b", 4'b0001);
    expect_pop("t2 q0c", 4'b0001);
    expect_pop("t2 q1", 4'b0010);
    expect_pop("t2 q2a", 4'b0100);
    expect_pop("t2 q2b", 4'b0100);
    expect_pop("t2 q3", 4'b1000);
    expect_pop("t2 q0 again", 4'b0001);

    // Sparse: only q2 requests
    weights = 16'h2222;
    empty   = 4'b1011;
    do_reset("t3");
    expect_pop("t3 idle", 4'b0000);
    expect_pop("t3 q2a", 4'b0100);
    expect_pop("t3 q2b", 4'b0100);
    expect_pop("t3 q2c", 4'b0100);
    expect_pop("t3 q2d", 4'b0100);
    chk("t3 busy", 16'(busy), 16'h1);
    empty = 4'b1111;
    expect_pop("t3 drained", 4'b0000);
    chk("t3 busy fell", 16'(busy), 16'h0);

    // Backpressure on q1 (weight 3) after its first pop
    weights = 16'h1131;
    empty   = 4'b0000;
    do_reset("t4");
    expect_pop("t4 idle", 4'b0000);
    expect_pop("t4 q0", 4'b0001);
    expect_pop("t4 q1 first", 4'b0010);
    dest_full = 1'b1;
    for (int i = 0; i < 5; i++) expect_pop("t4 stall", 4'b0000);
    chk("t4 grant held", 16'(grant_q), 16'h1);
    dest_full = 1'b0;
    expect_pop("t4 q1 second", 4'b0010);
    expect_pop("t4 q1 third", 4'b0010);
    expect_pop("t4 q2 next", 4'b0100);

    // Enable drop mid-burst on q1; search resumes after ptr=0
    weights = 16'h3331;
    do_reset("t5a");
    expect_pop("t5a idle", 4'b0000);
    expect_pop("t5a q0", 4'b0001);
    expect_pop("t5a q1", 4'b0010);
    enable = 1'b0;
    expect_pop("t5a disabled", 4'b0000);
    chk("t5a busy off", 16'(busy), 16'h0);
    enable = 1'b1;
    expect_pop("t5a idle again", 4'b0000);
    expect_pop("t5a q1 r1", 4'b0010);
    expect_pop("t5a q1 r2", 4'b0010);
    expect_pop("t5a q1 r3", 4'b0010);
    expect_pop("t5a q2", 4'b0100);

    // Reset pulse mid-burst on q1
    do_reset("t5b");
    expect_pop("t5b idle", 4'b0000);
    expect_pop("t5b q0", 4'b0001);
    expect_pop("t5b q1a", 4'b0010);
    expect_pop("t5b q1b", 4'b0010);
    chk("t5b pre-reset busy", 16'(busy), 16'h1);
    do_reset("t5b mid");
    expect_pop("t5b idle post", 4'b0000);
    expect_pop("t5b q0 post", 4'b0001);

    // Drain: q3 holds a single word, weight 4
    weights = 16'h4000;
    empty   = 4'b0111;
    do_reset("t6");
    expect_pop("t6 idle", 4'b0000);
    expect_pop("t6 q3", 4'b1000);
    empty = 4'b1111;
    chk("t6 busy bubble", 16'(busy), 16'h1);
    expect_pop("t6 bubble", 4'b0000);
    chk("t6 busy idle", 16'(busy), 16'h0);
    expect_pop("t6 idle after", 4'b0000);
    chk("t6 still idle", 16'(busy), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
